// File: rtl/alu_exec_sequencer_pkg.sv
// Shared definitions for the execute sequencer: widths, instruction field
// layout, ALU op codes and FSM state encoding.
package alu_exec_sequencer_pkg;

    // Datapath widths
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned RADDR_W = 3;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned ST_W    = 3;
    localparam int unsigned IMM_W   = 8;

    // Instruction field offsets: [15:13] op, [12] is_imm, [11:9] rd,
    // [8] reserved, [7:0] imm8 with rs overlaid on [2:0]
    localparam int unsigned OP_MSB   = 15;
    localparam int unsigned IMM_BIT  = 12;
    localparam int unsigned RD_MSB   = 11;
    localparam int unsigned RSVD_BIT = 8;
    localparam int unsigned IMM_MSB  = 7;
    localparam int unsigned RS_MSB   = 2;

    // ALU op codes
    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_CMP = 3'b101;
    localparam logic [OP_W-1:0] OP_MOV = 3'b110;
    localparam logic [OP_W-1:0] OP_NOP = 3'b111;

    // FSM state encoding
    localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
    localparam logic [ST_W-1:0] ST_READ = 3'd1;
    localparam logic [ST_W-1:0] ST_EXEC = 3'd2;
    localparam logic [ST_W-1:0] ST_CAPT = 3'd3;
    localparam logic [ST_W-1:0] ST_WB   = 3'd4;

    // MOV and NOP never use the ALU and go straight from READ to WB
    function automatic logic op_bypasses_alu(input logic [OP_W-1:0] op);
        return (op == OP_MOV) || (op == OP_NOP);
    endfunction

    // Only the arithmetic/logic ops write their ALU result back
    function automatic logic op_writes_result(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/alu_exec_sequencer.sv
// Multi-cycle execute controller for the 8-bit core. Owns the shared ALU:
// accepts one instruction per valid/ready handshake, reads operands from the
// register file, strobes the ALU, captures result/flags and writes back.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   instr_valid/instr/ready   upstream instruction handshake
//   rf_raddr_a/b, rf_rdata_a/b  register file read (rd / rs), combinational data
//   rf_we/rf_waddr/rf_wdata   register file write-back, one-cycle pulse
//   alu_in1/in2/select/active ALU operands (B / A), op code and strobe
//   alu_out/alu_c/alu_z       ALU result and flags
//   flag_c/flag_z             architectural flags, updated only by CMP
//   busy/done                 not idle / retire pulse
module alu_exec_sequencer
    import alu_exec_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic [RADDR_W-1:0] rf_raddr_a,
    output logic [RADDR_W-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0]  rf_rdata_a,
    input  logic [DATA_W-1:0]  rf_rdata_b,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic [DATA_W-1:0]  alu_in1,
    output logic [DATA_W-1:0]  alu_in2,
    output logic [OP_W-1:0]    alu_select,
    output logic               alu_active,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic               alu_c,
    input  logic               alu_z,
    output logic               flag_c,
    output logic               flag_z,
    output logic               busy,
    output logic               done
);

    logic [ST_W-1:0]    state_q,      state_d;
    logic [OP_W-1:0]    op_q,         op_d;
    logic               is_imm_q,     is_imm_d;
    logic [IMM_W-1:0]   imm_q,        imm_d;
    logic [RADDR_W-1:0] raddr_a_q,    raddr_a_d;
    logic [RADDR_W-1:0] raddr_b_q,    raddr_b_d;
    logic               rf_we_q,      rf_we_d;
    logic [RADDR_W-1:0] rf_waddr_q,   rf_waddr_d;
    logic [DATA_W-1:0]  rf_wdata_q,   rf_wdata_d;
    logic [DATA_W-1:0]  alu_in1_q,    alu_in1_d;
    logic [DATA_W-1:0]  alu_in2_q,    alu_in2_d;
    logic [OP_W-1:0]    alu_sel_q,    alu_sel_d;
    logic               alu_active_q, alu_active_d;
    logic               cap_c_q,      cap_c_d;
    logic               cap_z_q,      cap_z_d;
    logic               flag_c_q,     flag_c_d;
    logic               flag_z_q,     flag_z_d;
    logic               ready_q,      ready_d;
    logic               busy_q,       busy_d;
    logic               done_q,       done_d;

    logic [DATA_W-1:0]  operand_b_c;
    logic               rsvd_unused;

    // Reserved instruction bit is intentionally ignored
    assign rsvd_unused = instr[RSVD_BIT];

    // Second operand: immediate or rs register value
    assign operand_b_c = is_imm_q ? DATA_W'(imm_q) : rf_rdata_b;

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        is_imm_d     = is_imm_q;
        imm_d        = imm_q;
        raddr_a_d    = raddr_a_q;
        raddr_b_d    = raddr_b_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;
        alu_sel_d    = alu_sel_q;
        alu_active_d = 1'b0;
        cap_c_d      = cap_c_q;
        cap_z_d      = cap_z_q;
        flag_c_d     = flag_c_q;
        flag_z_d     = flag_z_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Read addresses are set on accept so the RF is addressed during READ
                if (instr_valid) begin
                    op_d       = instr[OP_MSB -: OP_W];
                    is_imm_d   = instr[IMM_BIT];
                    imm_d      = instr[IMM_MSB -: IMM_W];
                    raddr_a_d  = instr[RD_MSB -: RADDR_W];
                    raddr_b_d  = instr[RS_MSB -: RADDR_W];
                    rf_waddr_d = instr[RD_MSB -: RADDR_W];
                    state_d    = ST_READ;
                end
            end
            ST_READ: begin
                alu_in2_d = rf_rdata_a;
                alu_in1_d = operand_b_c;
                alu_sel_d = op_q;
                if (op_bypasses_alu(op_q)) begin
                    // WB outputs are registered here so they appear in the WB cycle
                    if (op_q == OP_MOV) begin
                        rf_we_d    = 1'b1;
                        rf_wdata_d = operand_b_c;
                    end
                    done_d  = 1'b1;
                    state_d = ST_WB;
                end else begin
                    alu_active_d = 1'b1;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                // Result is captured straight into the write-data register
                if (op_q == OP_CMP) begin
                    cap_c_d = alu_c;
                    cap_z_d = alu_z;
                end else if (op_writes_result(op_q)) begin
                    rf_we_d    = 1'b1;
                    rf_wdata_d = alu_out;
                end
                done_d  = 1'b1;
                state_d = ST_WB;
            end
            ST_WB: begin
                if (op_q == OP_CMP) begin
                    flag_c_d = cap_c_q;
                    flag_z_d = cap_z_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = ~ready_d;
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_ADD;
            is_imm_q     <= 1'b0;
            imm_q        <= '0;
            raddr_a_q    <= '0;
            raddr_b_q    <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            alu_sel_q    <= '0;
            alu_active_q <= 1'b0;
            cap_c_q      <= 1'b0;
            cap_z_q      <= 1'b0;
            flag_c_q     <= 1'b0;
            flag_z_q     <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            is_imm_q     <= is_imm_d;
            imm_q        <= imm_d;
            raddr_a_q    <= raddr_a_d;
            raddr_b_q    <= raddr_b_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
            alu_sel_q    <= alu_sel_d;
            alu_active_q <= alu_active_d;
            cap_c_q      <= cap_c_d;
            cap_z_q      <= cap_z_d;
            flag_c_q     <= flag_c_d;
            flag_z_q     <= flag_z_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign instr_ready = ready_q;
    assign rf_raddr_a  = raddr_a_q;
    assign rf_raddr_b  = raddr_b_q;
    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign alu_in1     = alu_in1_q;
    assign alu_in2     = alu_in2_q;
    assign alu_select  = alu_sel_q;
    assign alu_active  = alu_active_q;
    assign flag_c      = flag_c_q;
    assign flag_z      = flag_z_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
